// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared types and constants for the weight fetch controller: layer modes,
// FSM states, per-mode beat counts and the read credit depth.
package weight_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } op_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam int BEATS_MODE12 = 88;
  localparam int BEATS_MODE3  = 20;
  localparam int BEATS_MODE4  = 12;
  localparam int CREDIT_DEPTH = 4;

  localparam int CNT_W    = 7;
  localparam int CREDIT_W = 3;
  localparam int WORD_W   = 64;

  function automatic logic [CNT_W-1:0] beat_count(input op_mode_t mode);
    case (mode)
      MODE3:   beat_count = CNT_W'(BEATS_MODE3);
      MODE4:   beat_count = CNT_W'(BEATS_MODE4);
      default: beat_count = CNT_W'(BEATS_MODE12);
    endcase
  endfunction

endpackage

// File: rtl/weight_fetch_ctrl_fifo.sv
// Small synchronous FIFO holding returned read beats until the weight buffer
// takes them; flush empties it in one cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             not_empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_empty = (count != '0);
  assign do_push   = push && (count != CNT_W'(DEPTH));
  assign do_pop    = pop && not_empty;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Fetches one filter set of 64-bit weight words from memory under a 4-deep
// read credit and streams them to the weight buffer in order.
module weight_fetch_ctrl
  import weight_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  op_mode_t    mode_in,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        abort,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_gnt,
  input  logic        mem_rd_rvalid,
  input  logic [63:0] mem_rd_rdata,
  input  logic        wb_mem_req,
  output logic        mem_data_valid,
  output logic [63:0] weight_data,
  output logic        busy,
  output logic        done
);

  fetch_state_t        state;
  op_mode_t            mode_q;
  logic [31:0]         base_q;
  logic [CNT_W-1:0]    issued;
  logic [CNT_W-1:0]    delivered;
  logic [CNT_W-1:0]    total;
  logic [CREDIT_W-1:0] outstanding;
  logic [CREDIT_W-1:0] abort_cnt;
  logic [CREDIT_W-1:0] fifo_count;
  logic                fifo_not_empty;
  logic [WORD_W-1:0]   fifo_head;

  logic                grant;
  logic                rv_live;
  logic                rv_drop;
  logic                pop;
  logic [CNT_W-1:0]    issued_nxt;
  logic [CNT_W-1:0]    delivered_nxt;
  logic [CREDIT_W-1:0] outstanding_nxt;
  logic [CREDIT_W-1:0] fifo_count_nxt;
  logic [CREDIT_W-1:0] abort_cnt_nxt;
  logic [CREDIT_W:0]   credit_used;
  logic                req_nxt;
  logic [31:0]         addr_nxt;

  assign total   = beat_count(mode_q);
  assign grant   = mem_rd_req && mem_rd_gnt;
  // Beats still owed to an aborted fetch are swallowed before any new fetch starts.
  assign rv_drop = mem_rd_rvalid && (abort_cnt != '0);
  assign rv_live = mem_rd_rvalid && (abort_cnt == '0);
  assign pop     = mem_data_valid;

  assign mem_data_valid = fifo_not_empty && wb_mem_req;
  assign weight_data    = fifo_not_empty ? fifo_head : '0;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (CREDIT_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (rv_live),
    .push_data (mem_rd_rdata),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .not_empty (fifo_not_empty)
  );

  always_comb begin
    issued_nxt      = grant ? issued + CNT_W'(1) : issued;
    delivered_nxt   = pop ? delivered + CNT_W'(1) : delivered;
    outstanding_nxt = outstanding;
    if (grant && !rv_live)      outstanding_nxt = outstanding + CREDIT_W'(1);
    else if (!grant && rv_live) outstanding_nxt = outstanding - CREDIT_W'(1);
    fifo_count_nxt = fifo_count;
    if (rv_live && !pop)      fifo_count_nxt = fifo_count + CREDIT_W'(1);
    else if (!rv_live && pop) fifo_count_nxt = fifo_count - CREDIT_W'(1);
    abort_cnt_nxt = rv_drop ? abort_cnt - CREDIT_W'(1) : abort_cnt;
    // Every issued beat holds a credit until the weight buffer takes it, so the FIFO cannot overflow.
    credit_used = {1'b0, outstanding_nxt} + {1'b0, fifo_count_nxt};
    req_nxt     = (issued_nxt < total) && (credit_used < (CREDIT_W + 1)'(CREDIT_DEPTH));
    addr_nxt    = base_q + {22'd0, issued_nxt, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= MODE1;
      base_q      <= '0;
      issued      <= '0;
      delivered   <= '0;
      outstanding <= '0;
      abort_cnt   <= '0;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      issued      <= '0;
      delivered   <= '0;
      outstanding <= '0;
      abort_cnt   <= abort_cnt_nxt + outstanding_nxt;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      issued      <= issued_nxt;
      delivered   <= delivered_nxt;
      outstanding <= outstanding_nxt;
      abort_cnt   <= abort_cnt_nxt;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (abort_cnt == '0)) begin
            state       <= FETCH;
            mode_q      <= mode_in;
            base_q      <= base_addr;
            issued      <= '0;
            delivered   <= '0;
            outstanding <= '0;
            busy        <= 1'b1;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= base_addr;
          end
        end
        FETCH: begin
          if (grant && (issued == total - CNT_W'(1))) begin
            state       <= DRAIN;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
          end else begin
            mem_rd_req  <= req_nxt;
            mem_rd_addr <= req_nxt ? addr_nxt : '0;
          end
        end
        DRAIN: begin
          if (delivered_nxt == total) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed-plus-random bench for weight_fetch_ctrl: a memory model with
// configurable grant/latency and a scoreboard of the words handed out.
module tb_weight_fetch_ctrl;
  import weight_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  op_mode_t    mode_in;
  logic        start;
  logic [31:0] base_addr;
  logic        abort;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_rvalid;
  logic [63:0] mem_rd_rdata;
  logic        wb_mem_req;
  logic        mem_data_valid;
  logic [63:0] weight_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  weight_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mode_in        (mode_in),
    .start          (start),
    .base_addr      (base_addr),
    .abort          (abort),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_gnt     (mem_rd_gnt),
    .mem_rd_rvalid  (mem_rd_rvalid),
    .mem_rd_rdata   (mem_rd_rdata),
    .wb_mem_req     (wb_mem_req),
    .mem_data_valid (mem_data_valid),
    .weight_data    (weight_data),
    .busy           (busy),
    .done           (done)
  );

  typedef struct {
    int          due;
    logic [63:0] data;
  } resp_t;

  resp_t       resp_q[$];
  logic [63:0] exp_q[$];

  int          check_count = 0;
  int          pass_count  = 0;
  int          cyc = 0;
  int          grants, delivered, done_pulses, spurious, max_inflight, cur_total;
  logic [31:0] cur_base;
  int          gnt_mode, wb_mode, wb_release, lat;
  logic        abort_now, start_now, prev_pending;
  logic [31:0] prev_addr;

  function automatic int totalFor(input op_mode_t m);
    case (m)
      MODE3:   return 20;
      MODE4:   return 12;
      default: return 88;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock of the memory/buffer model; entered and left at posedge+1.
  task automatic applyStimulus();
    logic [63:0] d;
    case (gnt_mode)
      0:       mem_rd_gnt = 1'b1;
      1:       mem_rd_gnt = ((cyc % 2) == 0);
      default: mem_rd_gnt = ($urandom_range(0, 3) != 0);
    endcase
    case (wb_mode)
      0:       wb_mem_req = 1'b1;
      1:       wb_mem_req = (cyc >= wb_release);
      default: wb_mem_req = ($urandom_range(0, 2) != 0);
    endcase
    abort         = abort_now;
    start         = start_now;
    mem_rd_rvalid = 1'b0;
    mem_rd_rdata  = '0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      mem_rd_rvalid = 1'b1;
      mem_rd_rdata  = resp_q[0].data;
      void'(resp_q.pop_front());
    end
    #2;
    if (prev_pending) begin
      checkOutput("req_held", 64'(mem_rd_req), 64'd1);
      checkOutput("addr_held", 64'(mem_rd_addr), 64'(prev_addr));
    end
    if (mem_rd_req && mem_rd_gnt) begin
      checkOutput("rd_addr", 64'(mem_rd_addr), 64'(cur_base + 32'(grants * 8)));
      d = {$urandom, $urandom};
      resp_q.push_back('{due: cyc + lat, data: d});
      exp_q.push_back(d);
      grants++;
    end
    prev_pending = mem_rd_req && !mem_rd_gnt && !abort;
    prev_addr    = mem_rd_addr;
    if (mem_data_valid) begin
      if (exp_q.size() == 0) spurious++;
      else checkOutput("weight_data", weight_data, exp_q.pop_front());
      delivered++;
    end
    if (done) done_pulses++;
    if (grants - delivered > max_inflight) max_inflight = grants - delivered;
    if (abort) exp_q.delete();
    abort_now = 1'b0;
    start_now = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset(input int n);
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    mem_rd_gnt    = 1'b0;
    mem_rd_rvalid = 1'b0;
    mem_rd_rdata  = '0;
    wb_mem_req    = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    checkOutput("rst_req", 64'(mem_rd_req), 64'd0);
    checkOutput("rst_addr", 64'(mem_rd_addr), 64'd0);
    checkOutput("rst_valid", 64'(mem_data_valid), 64'd0);
    checkOutput("rst_wdata", weight_data, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    resp_q.delete();
    exp_q.delete();
    prev_pending = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic beginFetch(input op_mode_t m, input logic [31:0] b);
    mode_in      = m;
    base_addr    = b;
    start_now    = 1'b1;
    cur_base     = b;
    cur_total    = totalFor(m);
    grants       = 0;
    delivered    = 0;
    done_pulses  = 0;
    spurious     = 0;
    max_inflight = 0;
    applyStimulus();
    checkOutput("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic runUntilDone(input int budget);
    int n = 0;
    while (done_pulses == 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("done_within_budget", 64'(done_pulses > 0), 64'd1);
    repeat (3) applyStimulus();
    checkOutput("grants", 64'(grants), 64'(cur_total));
    checkOutput("delivered", 64'(delivered), 64'(cur_total));
    checkOutput("done_pulses", 64'(done_pulses), 64'd1);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("spurious_words", 64'(spurious), 64'd0);
    checkOutput("inflight_le_4", 64'(max_inflight <= 4), 64'd1);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    mode_in      = MODE1;
    base_addr    = '0;
    abort_now    = 1'b0;
    start_now    = 1'b0;
    prev_pending = 1'b0;
    gnt_mode     = 0;
    wb_mode      = 0;
    wb_release   = 0;
    lat          = 2;
    cur_base     = '0;
    doReset(3);

    // MODE1 streaming from 0x1000, rvalid two cycles after grant.
    beginFetch(MODE1, 32'h0000_1000);
    runUntilDone(400);

    // MODE4 with the weight buffer stalled for the first 20 cycles.
    wb_mode    = 1;
    wb_release = cyc + 20;
    beginFetch(MODE4, 32'h0002_4008);
    repeat (19) applyStimulus();
    checkOutput("stall_grants", 64'(grants), 64'd4);
    checkOutput("stall_delivered", 64'(delivered), 64'd0);
    runUntilDone(200);
    wb_mode = 0;

    // MODE3 with toggling grant, latency 5, and a start pulse while busy.
    gnt_mode = 1;
    lat      = 5;
    beginFetch(MODE3, 32'h0000_7F00);
    repeat (6) applyStimulus();
    mode_in   = MODE1;
    base_addr = 32'hDEAD_0000;
    start_now = 1'b1;
    runUntilDone(300);
    gnt_mode = 0;

    // MODE2 aborted after 10 words, then a fresh MODE4 fetch.
    lat = 4;
    beginFetch(MODE2, 32'h0010_0000);
    n = 0;
    while (delivered < 10 && n < 200) begin
      applyStimulus();
      n++;
    end
    abort_now = 1'b1;
    applyStimulus();
    checkOutput("busy_after_abort", 64'(busy), 64'd0);
    checkOutput("req_after_abort", 64'(mem_rd_req), 64'd0);
    if (resp_q.size() > 0) begin
      mode_in   = MODE4;
      base_addr = 32'h0000_2000;
      start_now = 1'b1;
      applyStimulus();
      checkOutput("start_ignored_draining", 64'(busy), 64'd0);
    end
    n = 0;
    while (resp_q.size() > 0 && n < 50) begin
      applyStimulus();
      n++;
    end
    repeat (2) applyStimulus();
    checkOutput("no_done_after_abort", 64'(done_pulses), 64'd0);
    checkOutput("no_words_after_abort", 64'(spurious), 64'd0);
    lat = 2;
    beginFetch(MODE4, 32'h0000_3000);
    runUntilDone(200);

    // Randomised grant, latency, buffer readiness and mode.
    gnt_mode = 2;
    wb_mode  = 2;
    for (int r = 0; r < 3; r++) begin
      lat = $urandom_range(1, 6);
      beginFetch(op_mode_t'(2'($urandom_range(0, 3))), $urandom & 32'hFFFF_FFF8);
      runUntilDone(2000);
    end
    gnt_mode = 0;
    wb_mode  = 0;

    // Reset in the middle of a MODE1 fetch, then a clean MODE4 fetch.
    lat = 2;
    beginFetch(MODE1, 32'h0000_8000);
    repeat (15) applyStimulus();
    mode_in   = MODE4;
    base_addr = 32'h0000_0040;
    start_now = 1'b1;
    applyStimulus();
    checkOutput("extra_start_grants", 64'(grants > 12), 64'd1);
    doReset(2);
    beginFetch(MODE4, 32'h0000_9000);
    runUntilDone(200);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on posedge clk.
REQ-002 SHALL have: rst_n  in  1  reset; synchronous, active-low.
REQ-003 SHALL have: mode_in  in  OP_MODE  layer mode; sampled on accepted start.
REQ-004 SHALL have: start  in  1  single-cycle pulse requesting one filter-set fetch.
REQ-005 SHALL have: base_addr  in  32  byte address of the first weight word; 8-byte aligned.
REQ-006 SHALL have: abort  in  1  drop the current fetch; driven by free_weight_buffer.
REQ-007 SHALL have: mem_rd_req  out  1  memory read request.
REQ-008 SHALL have: mem_rd_addr  out  32  read address; valid while mem_rd_req=1.
REQ-009 SHALL have: mem_rd_gnt  in  1  request accepted this cycle.
REQ-010 SHALL have: mem_rd_rvalid  in  1  read data returned; in order; never stalled.
REQ-011 SHALL have: mem_rd_rdata  in  64  returned data.
REQ-012 SHALL have: wb_mem_req  in  1  weight buffer is ready to take a word.
REQ-013 SHALL have: mem_data_valid  out  1  weight_data is valid to the weight buffer.
REQ-014 SHALL have: weight_data  out  64  weight word, 8 bytes.
REQ-015 SHALL have: busy  out  1  fetch in progress.
REQ-016 SHALL have: done  out  1  one-cycle pulse after the last word is delivered.

Function
REQ-017 SHALL fix the beat count per mode: MODE1/MODE2=88 (44 rows x 2 words), MODE3=20, MODE4=12.
REQ-018 SHALL use FSM states IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE->FETCH on start=1: latch mode_in, latch base_addr, clear issued and delivered counters; busy=1 from the next cycle.
REQ-020 SHALL ignore start in any state other than IDLE.
REQ-021 In FETCH, SHALL assert mem_rd_req when issued<total and (outstanding+fifo_count)<4; credit limit is 4.
REQ-022 SHALL drive mem_rd_addr = base + 8*issued; issued increments only on mem_rd_req&&mem_rd_gnt.
REQ-023 SHALL hold mem_rd_req and mem_rd_addr stable until granted.
REQ-024 FETCH->DRAIN on the grant of beat total-1; mem_rd_req=0 in DRAIN.
REQ-025 Each mem_rd_rvalid SHALL push mem_rd_rdata into a 4-entry response FIFO and decrement outstanding; overflow is impossible by the credit rule.
REQ-026 mem_data_valid SHALL equal fifo_not_empty && wb_mem_req, with weight_data = FIFO head; pop and delivered++ when mem_data_valid=1.
REQ-027 Latency rvalid->mem_data_valid SHALL be 1 cycle minimum (no bypass).
REQ-028 Grant and rvalid in the same cycle SHALL update outstanding by net 0.
REQ-029 DRAIN->DONE when delivered reaches total; DONE asserts done=1 for one cycle, then goes to IDLE with busy=0.
REQ-030 Counters SHALL be 7 bits (max 88); outstanding and fifo_count SHALL be 3 bits.
REQ-031 wb_mem_req=0 SHALL stall delivery only; issue continues up to the credit limit.
REQ-032 abort=1 in any state SHALL go to IDLE next cycle and flush the FIFO, with no done pulse.
REQ-033 After abort, SHALL discard the rvalid beats still outstanding; an abort counter holds the outstanding count, and start is ignored until it reaches 0.
REQ-034 abort and start in the same cycle: abort wins.

Reset
REQ-035 rst_n=0 SHALL force: state=IDLE; counters=0; FIFO empty; mem_rd_req=0, mem_rd_addr=0, mem_data_valid=0, weight_data=0, busy=0, done=0.
REQ-036 Reset mid-fetch SHALL discard all in-flight data; the memory side guarantees no rvalid after reset.

Structure
REQ-037 OP_MODE, the per-mode beat-count constants (88/20/12) and the credit depth (4) SHALL live in the shared package.
REQ-038 SHALL instantiate one sub-module, sync_fifo (parameterised width=64, depth=4), for response buffering.

Verification
REQ-039 MODE1, base=0x1000, gnt=1 and rvalid 2 cycles after grant, wb_mem_req=1 -> 88 words at addresses 0x1000..0x12B8 in order; one done pulse.
REQ-040 MODE4, wb_mem_req=0 for the first 20 cycles -> exactly 4 reads issued then stall; after release, 12 words delivered with none lost or duplicated.
REQ-041 MODE3, gnt toggling 1/0, rvalid latency 5 -> exactly 20 grants; addresses contiguous; outstanding never >4.
REQ-042 abort at delivered=10 in MODE2 with 3 beats outstanding -> no done pulse; 3 late rvalids dropped; next start (MODE4) delivers exactly 12 fresh words.
REQ-043 start pulses while busy, plus rst_n=0 mid-FETCH -> extra starts ignored; after reset all outputs are 0 and the FSM is in IDLE.
